// File: rtl/ip_codma_addr_phase.sv
// Address-phase controller for the codma engine: takes burst commands, wins the bus,
// issues one address beat per accepted bus cycle and pushes one tracker entry per burst.
module ip_codma_addr_phase #(
   parameter int unsigned NO_OF_AF_BUFFERS = 4,
   parameter int unsigned ADDR_W           = 32
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_write_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [3:0]        req_len_i,
   output logic              bus_req_o,
   input  logic              bus_gnt_i,
   input  logic              bus_ready_i,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [1:0]        bus_trans_o,
   output logic              bus_write_o,
   input  logic [4:0]        tk_count_i,
   output logic              tk_push_o,
   output logic              tk_write_o,
   output logic [1:0]        ap_state_o
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      AP_IDLE      = 2'b00,
      AP_BUS_REQ   = 2'b01,
      AP_RD_ACTIVE = 2'b10,
      AP_WR_ACTIVE = 2'b11
   } ap_state_e;

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;
   localparam logic [1:0] TRANS_SEQ    = 2'b11;

   ap_state_e         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              write_q, write_d;
   logic [CNT_W-1:0]  len_q, len_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              first_q, first_d;
   logic              room_c;
   logic              accept_c;

   // Tracker has room for another entry; the tracker count is already registered.
   assign room_c     = (tk_count_i < 5'(NO_OF_AF_BUFFERS));
   assign accept_c   = (state_q == AP_IDLE) && req_valid_i && room_c;
   assign ap_state_o = state_q;

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q <= AP_IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
         len_q   <= '0;
         cnt_q   <= '0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      write_d     = write_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      first_d     = first_q;
      req_ready_o = 1'b0;
      bus_req_o   = 1'b0;
      bus_addr_o  = addr_q;
      bus_trans_o = TRANS_IDLE;
      bus_write_o = 1'b0;
      tk_push_o   = 1'b0;
      tk_write_o  = 1'b0;

      unique case (state_q)
         AP_IDLE: begin
            req_ready_o = room_c;
            if (accept_c) begin
               addr_d  = req_addr_i & ~ADDR_W'(3);
               write_d = req_write_i;
               len_d   = req_len_i;
               cnt_d   = '0;
               first_d = 1'b1;
               state_d = AP_BUS_REQ;
            end
         end

         AP_BUS_REQ: begin
            bus_req_o = 1'b1;
            if (bus_gnt_i) begin
               state_d = write_q ? AP_WR_ACTIVE : AP_RD_ACTIVE;
            end
         end

         AP_RD_ACTIVE, AP_WR_ACTIVE: begin
            bus_req_o   = 1'b1;
            bus_addr_o  = addr_q + ADDR_W'({cnt_q, 2'b00});
            bus_trans_o = first_q ? TRANS_NONSEQ : TRANS_SEQ;
            bus_write_o = write_q;
            // Grant loss drops the beat; re-arbitrate and restart it as NONSEQ.
            if (!bus_gnt_i) begin
               state_d = AP_BUS_REQ;
               first_d = 1'b1;
            end else if (bus_ready_i) begin
               if (cnt_q == len_q) begin
                  state_d    = AP_IDLE;
                  tk_push_o  = 1'b1;
                  tk_write_o = write_q;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  first_d = 1'b0;
               end
            end
         end

         default: state_d = AP_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ip_codma_addr_phase.sv
// Bench for ip_codma_addr_phase: directed scenarios plus random traffic checked
// against a queue-based burst model and an emulated tracker.
module tb_ip_codma_addr_phase;

   localparam int unsigned NBUF = 4;
   localparam int unsigned AW   = 32;

   logic          clk_i = 1'b0;
   logic          reset_n_i;
   logic          req_valid_i;
   logic          req_ready_o;
   logic          req_write_i;
   logic [AW-1:0] req_addr_i;
   logic [3:0]    req_len_i;
   logic          bus_req_o;
   logic          bus_gnt_i;
   logic          bus_ready_i;
   logic [AW-1:0] bus_addr_o;
   logic [1:0]    bus_trans_o;
   logic          bus_write_o;
   logic [4:0]    tk_count_i;
   logic          tk_push_o;
   logic          tk_write_o;
   logic [1:0]    ap_state_o;

   int n_chk  = 0;
   int n_pass = 0;
   int pushes = 0;

   ip_codma_addr_phase #(.NO_OF_AF_BUFFERS(NBUF), .ADDR_W(AW)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
      .req_addr_i(req_addr_i), .req_len_i(req_len_i),
      .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .bus_ready_i(bus_ready_i),
      .bus_addr_o(bus_addr_o), .bus_trans_o(bus_trans_o), .bus_write_o(bus_write_o),
      .tk_count_i(tk_count_i), .tk_push_o(tk_push_o), .tk_write_o(tk_write_o),
      .ap_state_o(ap_state_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) if (tk_push_o) pushes++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Present a command in the current IDLE cycle, leaving the DUT in AP_BUS_REQ.
   task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] l);
      req_valid_i = 1'b1; req_write_i = w; req_addr_i = a; req_len_i = l;
      settle();
      chk("issue_ready", 32'(req_ready_o), 32'd1);
      tick();
      req_valid_i = 1'b0;
      settle();
      chk("issue_busreq_state", 32'(ap_state_o), 32'd1);
   endtask

   task automatic beat(input string tag, input logic [31:0] a, input logic [1:0] tr, input logic push);
      settle();
      chk({tag, "_addr"}, bus_addr_o, a);
      chk({tag, "_trans"}, 32'(bus_trans_o), 32'(tr));
      chk({tag, "_push"}, 32'(tk_push_o), 32'(push));
   endtask

   // Random-phase model: phase 0 idle, 1 awaiting grant, 2 issuing beats.
   int            ph;
   logic [31:0]   q[$];
   logic          m_write;
   logic          m_first;
   int            tk;
   logic          exp_push;
   logic          exp_ready;
   int            accepts;
   int            p0;

   initial begin
      reset_n_i = 1'b0; req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0;
      req_len_i = '0; bus_gnt_i = 1'b0; bus_ready_i = 1'b0; tk_count_i = '0;
      tick(); tick();

      // Reset state, then a single-beat read with immediate grant/ready.
      reset_n_i = 1'b1; bus_gnt_i = 1'b1; bus_ready_i = 1'b1;
      settle();
      chk("rst_state", 32'(ap_state_o), 32'd0);
      chk("rst_busreq", 32'(bus_req_o), 32'd0);
      chk("rst_trans", 32'(bus_trans_o), 32'd0);
      chk("rst_addr", bus_addr_o, 32'd0);
      chk("rst_write", 32'(bus_write_o), 32'd0);
      chk("rst_push", 32'(tk_push_o), 32'd0);
      chk("rst_tkw", 32'(tk_write_o), 32'd0);
      issue(1'b0, 32'h1000, 4'd0);
      chk("t1_busreq", 32'(bus_req_o), 32'd1);
      chk("t1_trans_req", 32'(bus_trans_o), 32'd0);
      tick();
      beat("t1_b0", 32'h1000, 2'b10, 1'b1);
      chk("t1_tkw", 32'(tk_write_o), 32'd0);
      chk("t1_state", 32'(ap_state_o), 32'd2);
      tick(); settle();
      chk("t1_idle", 32'(ap_state_o), 32'd0);
      chk("t1_pushes", 32'(pushes), 32'd1);

      // Unaligned write burst of four beats.
      issue(1'b1, 32'h2003, 4'd3);
      tick();
      for (int i = 0; i < 4; i++) begin
         beat("t2", 32'h2000 + 32'(4 * i), (i == 0) ? 2'b10 : 2'b11, i == 3);
         chk("t2_wr", 32'(bus_write_o), 32'd1);
         if (i == 3) chk("t2_tkw", 32'(tk_write_o), 32'd1);
         tick();
      end

      // Wait states on beat 1 hold the address.
      issue(1'b0, 32'h3000, 4'd2);
      tick();
      beat("t3_b0", 32'h3000, 2'b10, 1'b0);
      tick(); bus_ready_i = 1'b0;
      beat("t3_w0", 32'h3004, 2'b11, 1'b0);
      tick();
      beat("t3_w1", 32'h3004, 2'b11, 1'b0);
      tick(); bus_ready_i = 1'b1;
      beat("t3_b1", 32'h3004, 2'b11, 1'b0);
      tick();
      beat("t3_b2", 32'h3008, 2'b11, 1'b1);
      tick();

      // Grant drops on beat 2, returns three cycles later.
      p0 = pushes;
      issue(1'b1, 32'h4000, 4'd3);
      tick();
      beat("t4_b0", 32'h4000, 2'b10, 1'b0);
      tick();
      beat("t4_b1", 32'h4004, 2'b11, 1'b0);
      tick(); bus_gnt_i = 1'b0;
      beat("t4_drop", 32'h4008, 2'b11, 1'b0);
      tick(); settle();
      chk("t4_rearb", 32'(ap_state_o), 32'd1);
      chk("t4_rearb_trans", 32'(bus_trans_o), 32'd0);
      tick(); settle();
      chk("t4_wait", 32'(ap_state_o), 32'd1);
      tick(); bus_gnt_i = 1'b1; settle();
      chk("t4_regnt", 32'(ap_state_o), 32'd1);
      tick();
      beat("t4_resume", 32'h4008, 2'b10, 1'b0);
      chk("t4_wrstate", 32'(ap_state_o), 32'd3);
      tick();
      beat("t4_b3", 32'h400C, 2'b11, 1'b1);
      tick(); settle();
      chk("t4_pushes", 32'(pushes - p0), 32'd1);

      // Full tracker refuses a command until the count drops.
      tk_count_i = 5'd4; req_valid_i = 1'b1; req_write_i = 1'b0;
      req_addr_i = 32'h5000; req_len_i = 4'd0;
      settle();
      chk("t5_full_rdy", 32'(req_ready_o), 32'd0);
      tick(); settle();
      chk("t5_full_state", 32'(ap_state_o), 32'd0);
      chk("t5_full_rdy2", 32'(req_ready_o), 32'd0);
      tk_count_i = 5'd3; settle();
      chk("t5_room_rdy", 32'(req_ready_o), 32'd1);
      tick(); req_valid_i = 1'b0; settle();
      chk("t5_acc_state", 32'(ap_state_o), 32'd1);
      tick();
      beat("t5_b0", 32'h5000, 2'b10, 1'b1);
      tick(); tk_count_i = 5'd0;

      // Address wrap past the top of memory.
      issue(1'b0, 32'hFFFF_FFF8, 4'd3);
      tick();
      for (int i = 0; i < 4; i++) begin
         beat("t6_wrap", 32'hFFFF_FFF8 + 32'(4 * i), (i == 0) ? 2'b10 : 2'b11, i == 3);
         tick();
      end

      // Reset mid-burst discards it without a push.
      p0 = pushes;
      issue(1'b1, 32'h6000, 4'd3);
      tick();
      beat("t7_b0", 32'h6000, 2'b10, 1'b0);
      tick(); reset_n_i = 1'b0;
      tick(); reset_n_i = 1'b1; bus_gnt_i = 1'b0; settle();
      chk("t7_state", 32'(ap_state_o), 32'd0);
      chk("t7_trans", 32'(bus_trans_o), 32'd0);
      chk("t7_push", 32'(tk_push_o), 32'd0);
      chk("t7_addr", bus_addr_o, 32'd0);
      chk("t7_pushes", 32'(pushes - p0), 32'd0);

      // Random traffic with an emulated tracker.
      ph = 0; tk = 0; exp_push = 1'b0; accepts = 0; p0 = pushes;
      m_write = 1'b0; m_first = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         tk = tk + int'(exp_push);
         if (tk > 0 && ($urandom % 3) == 0) tk--;
         tk_count_i  = 5'(tk);
         req_valid_i = ($urandom % 2) == 0;
         req_write_i = $urandom % 2;
         req_addr_i  = $urandom;
         req_len_i   = (($urandom % 4) == 0) ? 4'($urandom) : 4'($urandom % 4);
         bus_gnt_i   = ($urandom % 5) != 0;
         bus_ready_i = ($urandom % 4) != 0;
         settle();

         exp_ready = (ph == 0) && (tk < int'(NBUF));
         exp_push  = (ph == 2) && bus_gnt_i && bus_ready_i && (q.size() == 1);
         chk("r_ready", 32'(req_ready_o), 32'(exp_ready));
         chk("r_push", 32'(tk_push_o), 32'(exp_push));
         chk("r_state", 32'(ap_state_o), (ph == 2) ? (m_write ? 32'd3 : 32'd2) : 32'(ph));
         chk("r_busreq", 32'(bus_req_o), 32'(ph != 0));
         if (ph == 2) begin
            chk("r_addr", bus_addr_o, q[0]);
            chk("r_trans", 32'(bus_trans_o), m_first ? 32'd2 : 32'd3);
            chk("r_write", 32'(bus_write_o), 32'(m_write));
            if (exp_push) chk("r_tkw", 32'(tk_write_o), 32'(m_write));
         end else begin
            chk("r_trans_idle", 32'(bus_trans_o), 32'd0);
            chk("r_write_idle", 32'(bus_write_o), 32'd0);
         end
         if (tk > int'(NBUF)) chk("r_overflow", 32'(tk), 32'(NBUF));

         case (ph)
            0: if (req_valid_i && exp_ready) begin
                  q.delete();
                  for (int k = 0; k <= int'(req_len_i); k++)
                     q.push_back({req_addr_i[31:2], 2'b00} + 32'(4 * k));
                  m_write = req_write_i; m_first = 1'b1; ph = 1; accepts++;
               end
            1: if (bus_gnt_i) ph = 2;
            default: begin
               if (!bus_gnt_i) begin
                  ph = 1; m_first = 1'b1;
               end else if (bus_ready_i) begin
                  void'(q.pop_front());
                  m_first = 1'b0;
                  if (q.size() == 0) ph = 0;
               end
            end
         endcase
      end
      tick(); settle();
      chk("r_push_total", 32'(pushes - p0), 32'(accepts - ((ph != 0) ? 1 : 0)));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
